// File: rtl/video_ram_arbiter.sv
// Shares one single-port video RAM between refresh, CPU and blitter, one arbitration slot per clk_en.
// Optional CPU starvation guard: define VRAM_ARB_STARVE_GUARD_EN.
module video_ram_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              video_slot,
   input  logic [13:0]       video_addr,
   output logic              video_valid,
   output logic [DATA_W-1:0] video_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              blt_req,
   input  logic              blt_we,
   input  logic [ADDR_W-1:0] blt_addr,
   input  logic [DATA_W-1:0] blt_wdata,
   output logic              blt_ack,
   output logic [DATA_W-1:0] blt_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   typedef enum logic [1:0] {OWN_IDLE, OWN_VIDEO, OWN_CPU, OWN_BLT} owner_t;

   owner_t            grant, s1_owner, s2_owner;
   logic              s1_we;
   logic              cpu_busy, blt_busy;
   logic              cpu_elig, blt_elig, starve_force;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   assign cpu_elig = cpu_req && !cpu_busy;
   assign blt_elig = blt_req && !blt_busy;

`ifdef VRAM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 2);
   logic [CNT_W-1:0] starve_cnt;

   assign starve_force = (starve_cnt == CNT_W'(STARVE_MAX));

   // Counts blitter wins only while the CPU is actually waiting.
   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (!cpu_elig || grant == OWN_CPU)
         starve_cnt <= '0;
      else if (grant == OWN_BLT)
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   logic unused_starve_max;
   assign unused_starve_max = ^STARVE_MAX;
   assign starve_force      = 1'b0;
`endif

   always_comb begin
      grant = OWN_IDLE;
      if (clk_en) begin
         if (video_slot)
            grant = OWN_VIDEO;
         else if (starve_force && cpu_elig)
            grant = OWN_CPU;
         else if (blt_elig)
            grant = OWN_BLT;
         else if (cpu_elig)
            grant = OWN_CPU;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_owner <= OWN_IDLE;
         s2_owner <= OWN_IDLE;
         s1_we    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cpu_busy <= 1'b0;
         blt_busy <= 1'b0;
      end else begin
         s1_owner <= grant;
         s2_owner <= s1_owner;
         s1_we    <= 1'b0;
         unique case (grant)
            OWN_VIDEO: addr_q <= ADDR_W'(video_addr);
            OWN_CPU: begin
               addr_q  <= cpu_addr;
               s1_we   <= cpu_we;
               wdata_q <= cpu_wdata;
            end
            OWN_BLT: begin
               addr_q  <= blt_addr;
               s1_we   <= blt_we;
               wdata_q <= blt_wdata;
            end
            default: ;
         endcase
         // Busy stays set through the ack cycle, so the next grant is at least one slot later.
         if (grant == OWN_CPU)
            cpu_busy <= 1'b1;
         else if (s2_owner == OWN_CPU)
            cpu_busy <= 1'b0;
         if (grant == OWN_BLT)
            blt_busy <= 1'b1;
         else if (s2_owner == OWN_BLT)
            blt_busy <= 1'b0;
      end
   end

   assign ram_addr    = addr_q;
   assign ram_wdata   = wdata_q;
   assign ram_we      = s1_we && !rst;
   assign video_valid = (s2_owner == OWN_VIDEO);
   assign cpu_ack     = (s2_owner == OWN_CPU);
   assign blt_ack     = (s2_owner == OWN_BLT);
   assign video_rdata = video_valid ? ram_rdata : '0;
   assign cpu_rdata   = cpu_ack ? ram_rdata : '0;
   assign blt_rdata   = blt_ack ? ram_rdata : '0;
endmodule

// File: doc/video_ram_arbiter.md
# video_ram_arbiter

Shares the single-port video RAM between three requesters: video refresh, the CPU and the blitter. Access slots are tied to the video counter's `clk_en` phase, so refresh fetches are never delayed. The CPU and the blitter are served with fixed priority and a registered, pipelined request/acknowledge handshake. The block sits between the video counter, the CPU bus interface, the blitter and the RAM macro.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 8, RAM data width
- STARVE_MAX, 8, consecutive blitter grants allowed while the CPU waits (only used with the starvation guard)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- clk_en  in  1  slot strobe, one arbitration slot per asserted cycle
- video_slot  in  1  current slot belongs to refresh; qualified by clk_en
- video_addr  in  14  refresh address, zero-extended to ADDR_W
- video_valid  out  1  one-clk pulse, video_rdata valid
- video_rdata  out  DATA_W  refresh read data
- cpu_req, cpu_we  in  1 each  CPU request / write enable
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-clk completion pulse
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack
- blt_req, blt_we, blt_addr, blt_wdata, blt_ack, blt_rdata  —  blitter port, same widths and meaning as the CPU port
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered write strobe, one clk wide
- ram_wdata  out  DATA_W  registered write data
- ram_rdata  in  DATA_W  synchronous RAM read data, one clk after the address

## Operation
- Arbitration happens only on edges where clk_en=1. Owner priority for the slot:
  - video_slot=1 → VIDEO
  - else eligible blt_req → BLT
  - else eligible cpu_req → CPU
  - else IDLE
- A requester is eligible only when req=1 and it has no access in flight (issued but not yet acked).
- Per-requester in-flight states: FREE → ISSUED (at grant) → FREE (on the ack cycle).
- Each pipeline stage carries an owner tag {IDLE, VIDEO, CPU, BLT}. Stage 1 holds the RAM command; stage 2 routes ram_rdata.
- VIDEO slots never write. Refresh is not a handshake; video_valid simply pulses.
- Requesters hold addr, we and wdata stable from req until ack. If req drops after grant, the access still completes and ack still pulses.
- Write ack: cpu_ack/blt_ack pulses; rdata is don't-care.
- ram_addr holds its last value when idle; ram_we is 0 in every cycle except a write's stage-1 cycle.

## Timing
- Slot at edge N: ram_addr/ram_we/ram_wdata valid in cycle N+1, ram_rdata in N+2, and ack or video_valid pulses in N+2 with the data.
- Latency from grant edge to ack is 2 clk regardless of clk_en spacing. Back-to-back slots (clk_en=1 every clk) are fully pipelined.
- The same requester's next grant can come no earlier than the first slot edge after its ack cycle.
- video_slot=1 with clk_en=0 is ignored.
- Reset values: all outputs 0; both in-flight flags FREE; stage tags IDLE; starvation counter 0.
- Reset mid-operation drops in-flight accesses with no ack and no ram_we. Write pulses in stage 1 are suppressed in the same cycle rst is asserted.

## Configuration
- `VRAM_ARB_STARVE_GUARD_EN` defined:
  - A counter increments on each BLT grant made while cpu_req is eligible.
  - When the counter equals STARVE_MAX, the next non-video slot goes to CPU.
  - The counter clears on any CPU grant or when cpu_req is not eligible.
- Not defined: strict blitter priority; the CPU can be starved indefinitely. The counter logic is absent.

## Test plan
- Single CPU read of 0x1234, RAM holding 0x5A, clk_en every 4 clk → ram_addr=0x1234 one clk after the slot; cpu_ack with cpu_rdata=0x5A two clk after the slot.
- cpu_req and blt_req held together, video_slot=0, clk_en every clk → BLT granted first; each requester acks no more than once per 3 clk; no double grant.
- video_slot=1 while both requesters are pending → ram_addr={2'b00,video_addr}, ram_we=0, video_valid in N+2, no ack that slot.
- Blitter write of 0xC3 to 0x0800 → ram_we high for exactly 1 clk with ram_wdata=0xC3, blt_ack in the following clk.
- rst asserted the clk after a CPU write grant → no ram_we pulse, no cpu_ack, all outputs 0.
- With `VRAM_ARB_STARVE_GUARD_EN` and STARVE_MAX=8, blt_req and cpu_req held → CPU granted on the 9th non-video slot. Without the macro → no CPU grant within 100 slots.
